axis_switch_single_slave: RTL and testbench
===========================================

Name: axis_switch_single_slave

Overview:
- 1-to-N AXI-Stream demultiplexer. Routes one slave stream to one of NMASTERS master ports, selected by TDEST.
- Sits downstream of the N-to-1 switch; fans command/data streams out to accelerator ports.
- Has a one-entry registered holding stage, so output is 1 cycle after input.
- When HAS_LAST=1, the whole packet is locked to the port chosen on its first beat.

Parameters:
- NMASTERS, 2, number of master (output) ports; must be >=1.
- DATA_WIDTH, 64, TDATA width.
- DEST_WIDTH, 1, TDEST width; must be >= clog2(NMASTERS) when NMASTERS>1.
- ID_WIDTH, 1, TID width.
- HAS_ID, 0, 1 = TID forwarded; 0 = m_id driven 0.
- HAS_LAST, 0, 1 = packet lock until TLAST; 0 = every beat routed independently, m_last driven 0.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous reset, active-high.
- s_valid  in  1  slave TVALID.
- s_ready  out  1  slave TREADY.
- s_data  in  DATA_WIDTH  slave TDATA.
- s_dest  in  DEST_WIDTH  slave TDEST; selects the target port.
- s_id  in  ID_WIDTH  slave TID.
- s_last  in  1  slave TLAST.
- m_valid  out  NMASTERS  per-port TVALID.
- m_ready  in  NMASTERS  per-port TREADY.
- m_data  out  NMASTERS*DATA_WIDTH  port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]; all slices carry the held beat.
- m_dest  out  NMASTERS*DEST_WIDTH  held TDEST, replicated per port.
- m_id  out  NMASTERS*ID_WIDTH  held TID, replicated per port.
- m_last  out  NMASTERS  held TLAST, replicated per port.

Behaviour:
- Holding register contents: data, dest, id, last, tgt (port index), full.
- Reset (areset=1 at a clock edge):
  - full=0, all m_valid=0, state=IDLE, lock cleared.
  - s_ready=0 while areset is high.
  - A partially forwarded packet is discarded; no recovery is attempted.
- Outputs:
  - m_valid[i] = full && tgt==i.
  - drain = full && m_ready[tgt].
  - s_ready = !areset && (!full || drain).
  - Back-to-back beats are accepted at 1 beat/clk while the target port is ready.
- Accept = s_valid && s_ready. On accept:
  - The register loads the beat.
  - tgt is computed as below.
  - full is set, or stays set.
- On drain with no accept, full clears.
- Latency: beat accepted in cycle n appears on m_valid[tgt] in cycle n+1.
- FSM (HAS_LAST=1):
  - IDLE: an accepted beat takes tgt=s_dest and latches lock_tgt=s_dest. If s_last=0, go to TRANSACTION; if s_last=1 (single-beat packet), stay in IDLE.
  - TRANSACTION: every accepted beat takes tgt=lock_tgt and s_dest is ignored. Go to IDLE on the accept of a beat with s_last=1.
  - Transitions follow input accepts, not output drains.
- HAS_LAST=0: no lock. Each beat takes tgt=s_dest and the FSM stays in IDLE.
- Blocking: a stalled target port (m_ready[tgt]=0) blocks s_ready. There is no head-of-line bypass.
- Out-of-range destination (s_dest >= NMASTERS, on a beat that starts a routing decision):
  - The beat is accepted and dropped; it is never presented on any port.
  - If it starts a packet (HAS_LAST=1), the whole packet is dropped through its TLAST.
  - Drop mode holds the FSM in TRANSACTION with a drop flag.
- NMASTERS=1: s_dest is ignored and tgt=0; the registered stage is still present.
- Simultaneous drain and accept in the same cycle: the register is overwritten and full stays 1.

Optional Feature:
- Macro: AXIS_SWITCH_DEST_ERR_EN.
- Defined:
  - Adds output dest_err (1 bit): pulses high for 1 cycle, registered, on each accepted beat that starts a drop.
  - Adds output dest_err_cnt (16 bits): counts drop events, saturates at 0xFFFF, cleared by areset.
- Undefined: neither port exists; out-of-range beats are dropped silently.

Test Plan:
1. NMASTERS=4, HAS_LAST=0, all m_ready=1. Send beats with dest 0,1,2,3, data 0xA0..0xA3, back-to-back. Required: m_valid[k] high in cycle k+1 with data 0xA0+k; s_ready held at 1 throughout.
2. HAS_LAST=1. Send a 3-beat packet with s_dest=2 on beat 1 and s_dest=0 on beats 2-3. Required: all 3 beats appear on port 2; FSM returns to IDLE after the beat with TLAST.
3. Backpressure: m_ready[1]=0 for 5 cycles with a beat to port 1 held. Required: data stable on port 1, s_ready=0, no other m_valid asserted. After m_ready[1]=1, the beat transfers and s_ready=1 on the same cycle.
4. NMASTERS=3, send a 2-beat packet with s_dest=3. Required: both beats accepted, no m_valid asserted. With AXIS_SWITCH_DEST_ERR_EN: one dest_err pulse and dest_err_cnt=1.
5. Assert areset during beat 2 of a 4-beat packet to port 1. Required: m_valid=0 and s_ready=0 during reset. The next packet, with s_dest=0, routes to port 0.

Source files
------------

// File: rtl/axis_switch_single_slave.sv
// 1-to-NMASTERS AXI-Stream demux with a one-entry registered holding stage and optional packet lock.
// Define AXIS_SWITCH_DEST_ERR_EN to add the dest_err pulse and saturating dest_err_cnt outputs.
module axis_switch_single_slave #(
    parameter int NMASTERS   = 2,
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1,
    parameter int HAS_ID     = 0,
    parameter int HAS_LAST   = 0
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic [DEST_WIDTH-1:0]          s_dest,
    input  logic [ID_WIDTH-1:0]            s_id,
    input  logic                           s_last,
    output logic [NMASTERS-1:0]            m_valid,
    input  logic [NMASTERS-1:0]            m_ready,
    output logic [NMASTERS*DATA_WIDTH-1:0] m_data,
    output logic [NMASTERS*DEST_WIDTH-1:0] m_dest,
    output logic [NMASTERS*ID_WIDTH-1:0]   m_id,
    output logic [NMASTERS-1:0]            m_last
`ifdef AXIS_SWITCH_DEST_ERR_EN
    ,
    output logic                           dest_err,
    output logic [15:0]                    dest_err_cnt
`endif
);

    localparam int TGT_W = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int CMP_W = DEST_WIDTH + 32;

    typedef enum logic {
        IDLE,
        TRANSACTION
    } state_t;

    state_t                state_q, state_d;
    logic [TGT_W-1:0]      tgt_q, tgt_d;
    logic [TGT_W-1:0]      lock_tgt_q, lock_tgt_d;
    logic                  drop_q, drop_d;
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  last_q;

    logic                  drain;
    logic                  accept;
    logic                  load;
    logic                  dest_ok;
    logic [TGT_W-1:0]      dest_tgt;

    for (genvar gi = 0; gi < NMASTERS; gi++) begin : g_valid
        assign m_valid[gi] = full_q && (tgt_q == TGT_W'(gi));
    end

    // A single-port switch has nowhere else to send a beat, so TDEST is never out of range.
    if (NMASTERS == 1) begin : g_single
        assign dest_ok  = 1'b1;
        assign dest_tgt = '0;
    end else begin : g_multi
        assign dest_ok  = (CMP_W'(s_dest) < CMP_W'(NMASTERS));
        assign dest_tgt = s_dest[TGT_W-1:0];
    end

    assign drain   = |(m_valid & m_ready);
    assign s_ready = !areset && (!full_q || drain);
    assign accept  = s_valid && s_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d    = state_q;
        tgt_d      = tgt_q;
        lock_tgt_d = lock_tgt_q;
        drop_d     = drop_q;
        load       = 1'b0;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (dest_ok) begin
                        load       = 1'b1;
                        tgt_d      = dest_tgt;
                        lock_tgt_d = dest_tgt;
                    end
                    if ((HAS_LAST != 0) && !s_last) begin
                        state_d = TRANSACTION;
                        drop_d  = !dest_ok;
                    end
                end
                TRANSACTION: begin
                    if (!drop_q) begin
                        load  = 1'b1;
                        tgt_d = lock_tgt_q;
                    end
                    if (s_last) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        full_d = load || (full_q && !drain);
    end

    always_ff @(posedge aclk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (areset) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            lock_tgt_q <= '0;
            drop_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            lock_tgt_q <= lock_tgt_d;
            drop_q     <= drop_d;
            full_q     <= full_d;
        end
    end

    always_ff @(posedge aclk) begin
        // NOTE: payload registers carry no reset; full_q alone qualifies their contents.
        if (load) begin
            data_q <= s_data;
            dest_q <= s_dest;
            id_q   <= s_id;
            last_q <= s_last;
        end
    end

    assign m_data = {NMASTERS{data_q}};
    assign m_dest = {NMASTERS{dest_q}};
    assign m_id   = (HAS_ID != 0)   ? {NMASTERS{id_q}}   : '0;
    assign m_last = (HAS_LAST != 0) ? {NMASTERS{last_q}} : '0;

`ifdef AXIS_SWITCH_DEST_ERR_EN
    logic start_drop;

    // Only the beat that opens a routing decision can start a drop; later beats of the packet follow it.
    assign start_drop = accept && (state_q == IDLE) && !dest_ok;

    always_ff @(posedge aclk) begin
        if (areset) begin
            dest_err     <= 1'b0;
            dest_err_cnt <= '0;
        end else begin
            dest_err <= start_drop;
            if (start_drop && (dest_err_cnt != 16'hFFFF)) begin
                dest_err_cnt <= dest_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_switch_single_slave.sv
// Scoreboard bench: DUT A (3 ports, packet lock, TID) and DUT B (4 ports, per-beat routing).
// Expected beats come from a packet-level routing model; a negedge monitor compares and pops them.
module tb_axis_switch_single_slave;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic [1:0]  dest;
        logic [1:0]  id;
        logic        last;
    } beat_t;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // DUT A: NMASTERS=3, HAS_LAST=1, HAS_ID=1
    logic        a_areset  = 1'b1;
    logic        a_s_valid = 1'b0;
    logic        a_s_ready;
    logic [31:0] a_s_data  = '0;
    logic [1:0]  a_s_dest  = '0;
    logic [1:0]  a_s_id    = '0;
    logic        a_s_last  = 1'b0;
    logic [2:0]  a_m_valid;
    logic [2:0]  a_m_ready = '1;
    logic [95:0] a_m_data;
    logic [5:0]  a_m_dest;
    logic [5:0]  a_m_id;
    logic [2:0]  a_m_last;
    bit          a_rand_rdy = 1'b0;

    // DUT B: NMASTERS=4, HAS_LAST=0, HAS_ID=0
    logic        b_areset  = 1'b1;
    logic        b_s_valid = 1'b0;
    logic        b_s_ready;
    logic [15:0] b_s_data  = '0;
    logic [1:0]  b_s_dest  = '0;
    logic [0:0]  b_s_id    = '0;
    logic        b_s_last  = 1'b0;
    logic [3:0]  b_m_valid;
    logic [3:0]  b_m_ready = '1;
    logic [63:0] b_m_data;
    logic [7:0]  b_m_dest;
    logic [3:0]  b_m_id;
    logic [3:0]  b_m_last;
    bit          b_rand_rdy = 1'b0;

`ifdef AXIS_SWITCH_DEST_ERR_EN
    logic        a_dest_err;
    logic [15:0] a_dest_err_cnt;
    logic        b_dest_err;
    logic [15:0] b_dest_err_cnt;
    bit          a_err_pend = 1'b0;
`endif

    axis_switch_single_slave #(
        .NMASTERS(3), .DATA_WIDTH(32), .DEST_WIDTH(2), .ID_WIDTH(2), .HAS_ID(1), .HAS_LAST(1)
    ) dut_a (
        .aclk(aclk), .areset(a_areset),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_dest(a_s_dest),
        .s_id(a_s_id), .s_last(a_s_last),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_dest(a_m_dest),
        .m_id(a_m_id), .m_last(a_m_last)
`ifdef AXIS_SWITCH_DEST_ERR_EN
        , .dest_err(a_dest_err), .dest_err_cnt(a_dest_err_cnt)
`endif
    );

    axis_switch_single_slave #(
        .NMASTERS(4), .DATA_WIDTH(16), .DEST_WIDTH(2), .ID_WIDTH(1), .HAS_ID(0), .HAS_LAST(0)
    ) dut_b (
        .aclk(aclk), .areset(b_areset),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_dest(b_s_dest),
        .s_id(b_s_id), .s_last(b_s_last),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_dest(b_m_dest),
        .m_id(b_m_id), .m_last(b_m_last)
`ifdef AXIS_SWITCH_DEST_ERR_EN
        , .dest_err(b_dest_err), .dest_err_cnt(b_dest_err_cnt)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level reference: a packet goes wherever its first beat's TDEST points, or nowhere.
    bit in_pkt[2];
    int pkt_port[2];
    bit pkt_drop[2];
    int drop_events[2];

    function automatic void route(input int u, input int nm, input bit has_last, input int dest,
                                  input bit last, output int port, output bit drop);
        if (!in_pkt[u]) begin
            port = dest;
            drop = (dest >= nm);
            if (drop) drop_events[u]++;
            if (has_last && !last) begin
                in_pkt[u]   = 1'b1;
                pkt_port[u] = port;
                pkt_drop[u] = drop;
            end
        end else begin
            port = pkt_port[u];
            drop = pkt_drop[u];
            if (last) in_pkt[u] = 1'b0;
        end
    endfunction

    beat_t qa[$];
    beat_t qb[$];
    beat_t ha, hb;
    bit    a_exp_rdy, b_exp_rdy, da, db;
    int    pa, pb;

    always @(negedge aclk) begin
        a_exp_rdy = !a_areset;
        if (qa.size() == 0) begin
            check("a_no_valid", a_m_valid, 0);
        end else begin
            ha = qa[0];
            check("a_valid", a_m_valid, 1 << ha.port);
            check("a_data", a_m_data, {3{ha.data}});
            check("a_dest", a_m_dest, {3{ha.dest}});
            check("a_id", a_m_id, {3{ha.id}});
            check("a_last", a_m_last, {3{ha.last}});
            if (a_m_ready[ha.port]) void'(qa.pop_front());
            else a_exp_rdy = 1'b0;
        end
        check("a_s_ready", a_s_ready, a_exp_rdy);
`ifdef AXIS_SWITCH_DEST_ERR_EN
        check("a_dest_err", a_dest_err, a_err_pend);
        check("a_dest_err_cnt", a_dest_err_cnt, drop_events[0]);
        a_err_pend = 1'b0;
`endif
        if (a_areset) begin
            qa.delete();
            in_pkt[0]      = 1'b0;
            drop_events[0] = 0;
        end else if (a_s_valid && a_s_ready) begin
`ifdef AXIS_SWITCH_DEST_ERR_EN
            pa = drop_events[0];
            route(0, 3, 1'b1, int'(a_s_dest), a_s_last, pa, da);
            a_err_pend = da && !in_pkt[0] ? (drop_events[0] != 0) : 1'b0;
`else
            route(0, 3, 1'b1, int'(a_s_dest), a_s_last, pa, da);
`endif
            if (!da) begin
                ha.port = pa; ha.data = a_s_data; ha.dest = a_s_dest;
                ha.id = a_s_id; ha.last = a_s_last;
                qa.push_back(ha);
            end
        end
    end

`ifdef AXIS_SWITCH_DEST_ERR_EN
    // A drop start is exactly a step of the model's drop-event count; track it independently.
    int a_prev_drops = 0;
    always @(negedge aclk) begin
        #1;
        a_err_pend   = (drop_events[0] != a_prev_drops) && (drop_events[0] != 0);
        a_prev_drops = drop_events[0];
    end
`endif

    always @(negedge aclk) begin
        b_exp_rdy = !b_areset;
        if (qb.size() == 0) begin
            check("b_no_valid", b_m_valid, 0);
        end else begin
            hb = qb[0];
            check("b_valid", b_m_valid, 1 << hb.port);
            check("b_data", b_m_data, {4{hb.data[15:0]}});
            check("b_dest", b_m_dest, {4{hb.dest}});
            check("b_id", b_m_id, 0);
            check("b_last", b_m_last, 0);
            if (b_m_ready[hb.port]) void'(qb.pop_front());
            else b_exp_rdy = 1'b0;
        end
        check("b_s_ready", b_s_ready, b_exp_rdy);
`ifdef AXIS_SWITCH_DEST_ERR_EN
        check("b_dest_err", b_dest_err, 1'b0);
`endif
        if (b_areset) begin
            qb.delete();
            in_pkt[1] = 1'b0;
        end else if (b_s_valid && b_s_ready) begin
            route(1, 4, 1'b0, int'(b_s_dest), b_s_last, pb, db);
            if (!db) begin
                hb.port = pb; hb.data = {16'h0, b_s_data}; hb.dest = b_s_dest;
                hb.id = '0; hb.last = b_s_last;
                qb.push_back(hb);
            end
        end
    end

    always begin
        @(posedge aclk);
        #2;
        if (a_rand_rdy) a_m_ready = 3'($urandom);
        if (b_rand_rdy) b_m_ready = 4'($urandom);
    end

    task automatic send_a(input logic [1:0] dest, input logic [31:0] data,
                          input logic [1:0] id, input logic last);
        int n;
        a_s_valid = 1'b1; a_s_dest = dest; a_s_data = data; a_s_id = id; a_s_last = last;
        n = 0;
        @(negedge aclk);
        while (!a_s_ready && n < 200) begin
            n++;
            @(negedge aclk);
        end
        check("a_accept_timeout", a_s_ready, 1'b1);
        @(posedge aclk);
        #1;
        a_s_valid = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] dest, input logic [15:0] data);
        int n;
        b_s_valid = 1'b1; b_s_dest = dest; b_s_data = data; b_s_last = 1'($urandom);
        n = 0;
        @(negedge aclk);
        while (!b_s_ready && n < 200) begin
            n++;
            @(negedge aclk);
        end
        check("b_accept_timeout", b_s_ready, 1'b1);
        @(posedge aclk);
        #1;
        b_s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        a_areset = 1'b0;
        b_areset = 1'b0;
        idle(1);

        // Back-to-back beats to every port of B, one per clock.
        for (int k = 0; k < 4; k++) send_b(2'(k), 16'(16'hA0 + k));
        idle(3);

        // Three-beat packet locked to port 2 although later beats carry TDEST 0.
        send_a(2'd2, 32'hC0DE_0001, 2'd1, 1'b0);
        send_a(2'd0, 32'hC0DE_0002, 2'd2, 1'b0);
        send_a(2'd0, 32'hC0DE_0003, 2'd3, 1'b1);
        send_a(2'd0, 32'hC0DE_0004, 2'd0, 1'b1);
        idle(2);

        // Port 1 stalls for five cycles while a second beat waits behind it.
        a_m_ready = 3'b101;
        send_a(2'd1, 32'h3001, 2'd2, 1'b1);
        fork
            send_a(2'd0, 32'h3002, 2'd0, 1'b1);
            begin
                idle(5);
                a_m_ready = 3'b111;
            end
        join
        idle(2);

        // Out-of-range two-beat packet is swallowed entirely.
        send_a(2'd3, 32'hDEAD_0001, 2'd1, 1'b0);
        send_a(2'd1, 32'hDEAD_0002, 2'd1, 1'b1);
        send_a(2'd3, 32'hDEAD_0003, 2'd0, 1'b1);
        send_a(2'd1, 32'hBEEF_0001, 2'd2, 1'b1);
        idle(3);

        // Reset in the middle of a packet to port 1; the next packet must route freely.
        send_a(2'd1, 32'h5000, 2'd1, 1'b0);
        a_s_valid = 1'b1; a_s_dest = 2'd1; a_s_data = 32'h5001; a_s_last = 1'b0;
        a_areset  = 1'b1;
        idle(2);
        a_areset  = 1'b0;
        a_s_valid = 1'b0;
        idle(1);
        send_a(2'd0, 32'h6000, 2'd3, 1'b1);
        idle(2);

        // Randomized traffic under random backpressure.
        a_rand_rdy = 1'b1;
        b_rand_rdy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            send_a(2'($urandom_range(0, 3)), $urandom, 2'($urandom), ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        send_a(2'd0, 32'hF1F1_F1F1, 2'd0, 1'b1);
        for (int i = 0; i < 150; i++) begin
            send_b(2'($urandom_range(0, 3)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        a_rand_rdy = 1'b0;
        b_rand_rdy = 1'b0;
        idle(1);
        a_m_ready = '1;
        b_m_ready = '1;
        idle(4);
        check("a_drained", qa.size(), 0);
        check("b_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
